rx_frame_sequencer: RTL and testbench



---
 rtl/rx_frame_pkg.sv | 20 ++
 rtl/rx_frame_sequencer_idle_timer.sv | 35 +++
 rtl/rx_frame_sequencer.sv | 141 ++++++++++++++
 tb/tb_rx_frame_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rx_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rx_frame_pkg
// Description : Shared state encoding and framing constants for the UART
//               receive-frame sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package rx_frame_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [63:0] C_SYNC_WORD  = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] C_STOP_WORD  = 64'h5555_5555_5555_5555;
    localparam int          C_BYTE_CNT_W = 3;

endpackage : rx_frame_pkg
`default_nettype wire

// File: rtl/rx_frame_sequencer_idle_timer.sv
`default_nettype none
// ============================================================================
// Module      : rx_idle_timer
// Description : Counts cycles since the last received byte while enabled and
//               raises a one-cycle expire flag at TIMEOUT_CYCLES-1.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_idle_timer #(
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int              TMR_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] C_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] r_count;

    // Saturates at the terminal value so the counter can never wrap back.
    always_ff @(posedge clk) begin
        if (reset || clear || !enable) begin
            r_count <= '0;
        end else if (r_count != C_LAST) begin
            r_count <= r_count + TMR_W'(1);
        end
    end

    assign expire = enable && !clear && (r_count == C_LAST);

endmodule : rx_idle_timer
`default_nettype wire

// File: rtl/rx_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rx_frame_sequencer
// Description : Hunts for a sync word in the UART byte stream, packs following
//               bytes into 64-bit blocks and hands them out over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_sequencer
    import rx_frame_pkg::*;
#(
    parameter logic [63:0] SYNC_WORD      = C_SYNC_WORD,
    parameter logic [63:0] STOP_WORD      = C_STOP_WORD,
    parameter int          TIMEOUT_CYCLES = 5000000,
    parameter int          CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             blk_ready,
    input  logic             clr_err,
    output logic [63:0]      blk_data,
    output logic             blk_valid,
    output logic             active,
    output logic             stop_seen,
    output logic             overrun,
    output logic             timeout,
    output logic [CNT_W-1:0] blk_count
);

    state_t                  r_state;
    // Only the 7 previous bytes are kept; the incoming byte completes the word.
    logic [55:0]             r_hunt;
    logic [55:0]             r_asm;
    logic [C_BYTE_CNT_W-1:0] r_byte_cnt;
    logic [63:0]             r_blk_data;
    logic                    r_blk_valid;
    logic                    r_stop_seen;
    logic                    r_overrun;
    logic                    r_timeout;
    logic [CNT_W-1:0]        r_blk_count;

    logic [55:0]             w_history;
    logic [63:0]             w_next_word;
    logic                    w_slot_free;
    logic                    w_last_byte;
    logic                    w_expire;

    assign w_history   = (r_state == ACTIVE) ? r_asm : r_hunt;
    assign w_next_word = {w_history, rx_data};
    assign w_slot_free = !r_blk_valid || blk_ready;
    assign w_last_byte = (r_byte_cnt == {C_BYTE_CNT_W{1'b1}});

    rx_idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (rx_valid || (r_state == IDLE)),
        .enable (r_state == ACTIVE),
        .expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_hunt      <= '0;
            r_asm       <= '0;
            r_byte_cnt  <= '0;
            r_blk_data  <= '0;
            r_blk_valid <= 1'b0;
            r_stop_seen <= 1'b0;
            r_overrun   <= 1'b0;
            r_timeout   <= 1'b0;
            r_blk_count <= '0;
        end else begin
            r_stop_seen <= 1'b0;

            if (r_blk_valid && blk_ready) begin
                r_blk_valid <= 1'b0;
            end

            // Set events below override this clear in the same cycle.
            if (clr_err) begin
                r_overrun <= 1'b0;
                r_timeout <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (rx_valid) begin
                        r_hunt <= w_next_word[55:0];
                        if (w_next_word == SYNC_WORD) begin
                            r_state    <= ACTIVE;
                            r_asm      <= '0;
                            r_byte_cnt <= '0;
                        end
                    end
                end

                ACTIVE: begin
                    if (rx_valid) begin
                        r_asm      <= w_next_word[55:0];
                        r_byte_cnt <= r_byte_cnt + C_BYTE_CNT_W'(1);
                        if (w_last_byte) begin
                            if (w_next_word == STOP_WORD) begin
                                r_state     <= IDLE;
                                r_stop_seen <= 1'b1;
                                r_hunt      <= '0;
                            end else if (w_slot_free) begin
                                r_blk_data  <= w_next_word;
                                r_blk_valid <= 1'b1;
                                r_blk_count <= r_blk_count + CNT_W'(1);
                            end else begin
                                r_overrun   <= 1'b1;
                            end
                        end
                    end else if (w_expire) begin
                        r_state    <= IDLE;
                        r_timeout  <= 1'b1;
                        r_hunt     <= '0;
                        r_asm      <= '0;
                        r_byte_cnt <= '0;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign blk_data  = r_blk_data;
    assign blk_valid = r_blk_valid;
    assign active    = (r_state == ACTIVE);
    assign stop_seen = r_stop_seen;
    assign overrun   = r_overrun;
    assign timeout   = r_timeout;
    assign blk_count = r_blk_count;

endmodule : rx_frame_sequencer
`default_nettype wire

// File: tb/tb_rx_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_frame_sequencer
// Description : Directed self-checking bench for rx_frame_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_frame_sequencer;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             blk_ready;
    logic             clr_err;
    logic [63:0]      blk_data;
    logic             blk_valid;
    logic             active;
    logic             stop_seen;
    logic             overrun;
    logic             timeout;
    logic [CNT_W-1:0] blk_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rx_frame_sequencer #(
        .SYNC_WORD      (64'hAAAA_AAAA_AAAA_AAAA),
        .STOP_WORD      (64'h5555_5555_5555_5555),
        .TIMEOUT_CYCLES (100),
        .CNT_W          (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .blk_ready (blk_ready),
        .clr_err   (clr_err),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .active    (active),
        .stop_seen (stop_seen),
        .overrun   (overrun),
        .timeout   (timeout),
        .blk_count (blk_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge after the byte is sampled.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_sync();
        for (int i = 0; i < 8; i++) send_byte(8'hAA);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        blk_ready = 1'b0;
        clr_err   = 1'b0;
        idle_cycles(3);

        check("rst_blk_valid", blk_valid, 0);
        check("rst_blk_data",  blk_data,  0);
        check("rst_active",    active,    0);
        check("rst_stop_seen", stop_seen, 0);
        check("rst_overrun",   overrun,   0);
        check("rst_timeout",   timeout,   0);
        check("rst_blk_count", blk_count, 0);
        reset = 1'b0;

        // Leading junk byte, then sync and one block
        blk_ready = 1'b1;
        send_byte(8'h12);
        for (int i = 0; i < 7; i++) send_byte(8'hAA);
        check("pre_sync_active", active, 0);
        send_byte(8'hAA);
        check("sync_active", active, 1);
        for (int i = 1; i <= 7; i++) send_byte(8'(i));
        check("b1_not_yet_valid", blk_valid, 0);
        send_byte(8'h08);
        check("b1_valid",  blk_valid, 1);
        check("b1_data",   blk_data,  64'h0102030405060708);
        check("b1_count",  blk_count, 1);
        idle_cycles(1);
        check("b1_accepted", blk_valid, 0);

        // Stop word closes the frame
        for (int i = 0; i < 7; i++) send_byte(8'h55);
        check("stop_not_yet", stop_seen, 0);
        send_byte(8'h55);
        check("stop_pulse",     stop_seen, 1);
        check("stop_active",    active,    0);
        check("stop_no_valid",  blk_valid, 0);
        check("stop_count",     blk_count, 1);
        idle_cycles(1);
        check("stop_pulse_end", stop_seen, 0);

        // Backpressure: first block held, second dropped
        send_sync();
        check("resync_active", active, 1);
        blk_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send_byte(8'h10 + 8'(i));
        check("bp_valid", blk_valid, 1);
        check("bp_data",  blk_data,  64'h1112131415161718);
        check("bp_count", blk_count, 2);
        for (int i = 1; i <= 8; i++) send_byte(8'h20 + 8'(i));
        check("ovr_flag",  overrun,   1);
        check("ovr_hold",  blk_data,  64'h1112131415161718);
        check("ovr_count", blk_count, 2);
        check("ovr_active", active,   1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("ovr_cleared", overrun, 0);

        // Slot freed in the same cycle as the 8th byte
        for (int i = 1; i <= 7; i++) send_byte(8'h20 + 8'(i));
        check("free_hold", blk_data, 64'h1112131415161718);
        blk_ready = 1'b1;
        send_byte(8'h28);
        blk_ready = 1'b0;
        check("free_no_ovr", overrun,   0);
        check("free_valid",  blk_valid, 1);
        check("free_data",   blk_data,  64'h2122232425262728);
        check("free_count",  blk_count, 3);
        blk_ready = 1'b1;
        idle_cycles(1);
        check("free_accepted", blk_valid, 0);

        // Inter-byte timeout with a partial block
        send_byte(8'h31);
        send_byte(8'h32);
        send_byte(8'h33);
        idle_cycles(99);
        check("to_still_active", active,  1);
        check("to_not_yet",      timeout, 0);
        idle_cycles(1);
        check("to_active",   active,    0);
        check("to_flag",     timeout,   1);
        check("to_no_valid", blk_valid, 0);
        check("to_count",    blk_count, 3);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("to_cleared", timeout, 0);

        // Reset in the middle of a block
        send_sync();
        send_byte(8'h41);
        send_byte(8'h42);
        send_byte(8'h43);
        send_byte(8'h44);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst_active",    active,    0);
        check("mrst_blk_count", blk_count, 0);
        check("mrst_blk_data",  blk_data,  0);
        check("mrst_blk_valid", blk_valid, 0);
        send_sync();
        for (int i = 1; i <= 8; i++) send_byte(8'h50 + 8'(i));
        check("mrst_b_valid", blk_valid, 1);
        check("mrst_b_data",  blk_data,  64'h5152535455565758);
        check("mrst_b_count", blk_count, 1);

        // A sync word inside a frame is ordinary payload
        send_sync();
        check("sync_payload_data",   blk_data,  64'hAAAAAAAAAAAAAAAA);
        check("sync_payload_valid",  blk_valid, 1);
        check("sync_payload_count",  blk_count, 2);
        check("sync_payload_active", active,    1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_rx_frame_sequencer
`default_nettype wire
